spec_log_mgr: RTL
=================

# spec_log_mgr

Speculative CF-Log manager sitting directly downstream of the block detector. When a speculated sub-path is confirmed (`detect_active`), it rewinds the ACFA CF-Log pointer to where the sub-path began and writes a single marker word in place of the logged transfers. It then records the (block id, log address) pair on a small speculation stack for the attestation report. While rewriting, it stalls ACFA hardware log writes.

## Interface
- `DEPTH`, 8: speculation stack entries (power of two, 2..64).
- `SPEC_TAG`, 4'hF: upper nibble of every marker word.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `detect_active`  in  1  one-cycle pulse from the block detector: block confirmed.
- `active_block_id`  in  8  id of the confirmed block.
- `active_block_cflog_addr`  in  16  CF-Log address of the block's first entry.
- `log_ptr_load`  out  1  force the ACFA CF-Log pointer to `log_ptr_value`.
- `log_ptr_value`  out  16  new CF-Log pointer.
- `log_wen`  out  1  marker write strobe into CF-Log.
- `log_addr`  out  16  marker write address.
- `log_data`  out  16  marker word `{SPEC_TAG, cnt[3:0], id[7:0]}`.
- `acfa_stall`  out  1  ACFA must hold `cflow_hw_wen` low this cycle.
- `stack_pop`  in  1  remove top entry.
- `stack_top_id`  out  8  id at top of stack.
- `stack_top_addr`  out  16  marker address at top of stack.
- `stack_count`  out  log2(DEPTH)+1  occupied entries.
- `stack_empty`  out  1  `stack_count == 0`.
- `stack_ovf`  out  1  sticky: a push was dropped because the stack was full.
- `busy_err`  out  1  sticky: `detect_active` arrived while not IDLE.

## Operation
- FSM states: IDLE, CAPTURE, WRITE.
- IDLE:
  - On `detect_active`, latch `id` and `addr`, then go to CAPTURE.
  - Otherwise stay in IDLE.
- CAPTURE (1 cycle):
  - Drive `acfa_stall=1`.
  - Evaluate the repeat decision (see Configuration). This yields `mk_addr`, `mk_cnt` and `push` (1 for a new marker, 0 for a repeat).
  - Go to WRITE.
- WRITE (1 cycle):
  - Drive `log_wen=1`, `log_addr=mk_addr`, `log_data={SPEC_TAG, mk_cnt, id}`.
  - Drive `log_ptr_load=1`, `log_ptr_value=mk_addr+1` (16-bit, wraps 16'hFFFF→16'h0000).
  - Drive `acfa_stall=1`.
  - If `push`, push `{id, mk_addr}`.
  - Update `last_id`, `last_addr=mk_addr`, `last_cnt=mk_cnt`, `last_valid=1`.
  - Go to IDLE.
- `detect_active` in CAPTURE or WRITE: ignored, `busy_err` set.
- Outputs `log_wen`, `log_ptr_load` and `acfa_stall` are 0 in IDLE. `log_addr`, `log_data` and `log_ptr_value` are 0 when their strobe is low.
- Stack is LIFO:
  - Push when full: dropped, `stack_ovf` set, count unchanged.
  - Pop when empty: ignored.
  - Push and pop in the same cycle: pop takes the old top, push writes the new top, count unchanged. If full, this is not an overflow.
  - `stack_top_*` shows the entry at count-1, or 0 when empty.
- Without compression:
  - `mk_addr=addr`, `mk_cnt=0`, `push=1`.

## Timing
- `detect_active` at cycle T → CAPTURE at T+1 → WRITE (marker write and pointer load) at T+2 → IDLE at T+3.
- `acfa_stall` is high during T+1 and T+2.
- `stack_count` reflects the push from T+3.
- Reset values:
  - State IDLE.
  - All outputs 0, except `stack_empty=1`.
  - Stack count 0.
  - `last_valid=0`.
  - Both sticky flags 0.
- Reset asserted in CAPTURE or WRITE: the FSM aborts to IDLE the next cycle. No write and no push occur in that cycle.
- Sticky flags clear only on `rst`.

## Configuration
- `SPEC_REPEAT_COMPRESS_EN` defined: loop compression.
  - In CAPTURE, a repeat requires all of:
    - `last_valid`
    - `id==last_id`
    - `addr==last_addr+1`
    - `last_cnt!=4'hF`
  - On a repeat, `mk_addr=last_addr`, `mk_cnt=last_cnt+1`, `push=0`. The existing marker is rewritten and the pointer returns to `last_addr+1`.
  - Otherwise the block gets a new marker with `cnt=0` and is pushed.
  - At saturation (`last_cnt==15`) a new marker is started.
- Macro undefined: no compression. Every detection writes a new marker with `cnt=0` and pushes. The `last_*` compare logic is absent.

## Test plan
- Single detection, `id=8'h05`, `addr=16'h0100` → T+2: `log_wen=1`, `log_addr=16'h0100`, `log_data=16'hF005`, `log_ptr_value=16'h0101`; T+3: `stack_count=1`, `stack_top_id=8'h05`, `stack_top_addr=16'h0100`.
- Two detections of id 8'h05 at 16'h0100 then 16'h0101:
  - With `SPEC_REPEAT_COMPRESS_EN`: the second writes `16'hF105` at `16'h0100`, pointer=16'h0101, `stack_count=1`.
  - Without the macro: the second writes `16'hF005` at `16'h0101`, `stack_count=2`.
- 17 consecutive repeats of id 8'h07 starting at 16'h0200, with compression enabled → counts 0..15 at 16'h0200; the 17th writes `16'hF007` at `16'h0201` and pushes.
- DEPTH=8: nine detections with distinct ids → `stack_count=8`, `stack_ovf=1`, top equals the 8th entry. Then push+pop in the same cycle → count stays 8, `stack_ovf` is not newly triggered.
- `detect_active` in CAPTURE → `busy_err=1`, exactly one marker written. `rst` in WRITE → no `log_wen` that cycle, all outputs at reset values the next cycle.
- `addr=16'hFFFF` → `log_ptr_value=16'h0000`.

Source files
------------

// File: rtl/spec_log_mgr_if.sv
// Bus bundle between the block detector / ACFA logger side (master) and spec_log_mgr (slave).
interface spec_log_mgr_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          detect_active;
  logic [7:0]    active_block_id;
  logic [15:0]   active_block_cflog_addr;
  logic          log_ptr_load;
  logic [15:0]   log_ptr_value;
  logic          log_wen;
  logic [15:0]   log_addr;
  logic [15:0]   log_data;
  logic          acfa_stall;
  logic          stack_pop;
  logic [7:0]    stack_top_id;
  logic [15:0]   stack_top_addr;
  logic [CW-1:0] stack_count;
  logic          stack_empty;
  logic          stack_ovf;
  logic          busy_err;

  modport master (
    output detect_active, active_block_id, active_block_cflog_addr, stack_pop,
    input  log_ptr_load, log_ptr_value, log_wen, log_addr, log_data, acfa_stall,
           stack_top_id, stack_top_addr, stack_count, stack_empty, stack_ovf, busy_err
  );

  modport slave (
    input  detect_active, active_block_id, active_block_cflog_addr, stack_pop,
    output log_ptr_load, log_ptr_value, log_wen, log_addr, log_data, acfa_stall,
           stack_top_id, stack_top_addr, stack_count, stack_empty, stack_ovf, busy_err
  );
endinterface

// File: rtl/spec_log_mgr.sv
// Speculative CF-Log manager: rewinds the log pointer, writes one marker word and keeps a LIFO of markers.
// Optional loop compression of repeated markers is enabled by defining SPEC_REPEAT_COMPRESS_EN.
module spec_log_mgr #(
  parameter int         DEPTH    = 8,
  parameter logic [3:0] SPEC_TAG = 4'hF
) (
  input logic           clk,
  input logic           rst,
  spec_log_mgr_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, WRITE} state_t;

  state_t        r_state;
  logic [7:0]    r_id;
  logic [15:0]   r_addr;
  logic          r_push;
  logic          r_logWen;
  logic          r_ptrLoad;
  logic          r_stall;
  logic [15:0]   r_logAddr;
  logic [15:0]   r_logData;
  logic [15:0]   r_ptrValue;
  logic          r_busyErr;

  logic [15:0]   w_mkAddr;
  logic [3:0]    w_mkCnt;
  logic          w_push;

`ifdef SPEC_REPEAT_COMPRESS_EN
  logic          r_lastValid;
  logic [7:0]    r_lastId;
  logic [15:0]   r_lastAddr;
  logic [3:0]    r_lastCnt;
  logic          w_repeat;

  // A repeat continues the previous marker when the same block restarts right after it.
  assign w_repeat = r_lastValid && (r_id == r_lastId) &&
                    (r_addr == r_lastAddr + 16'd1) && (r_lastCnt != 4'hF);
  assign w_mkAddr = w_repeat ? r_lastAddr : r_addr;
  assign w_mkCnt  = w_repeat ? r_lastCnt + 4'd1 : 4'd0;
  assign w_push   = !w_repeat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastValid <= 1'b0;
      r_lastId    <= '0;
      r_lastAddr  <= '0;
      r_lastCnt   <= '0;
    end else if (r_state == WRITE) begin
      r_lastValid <= 1'b1;
      r_lastId    <= r_id;
      r_lastAddr  <= r_logAddr;
      r_lastCnt   <= r_logData[11:8];
    end
  end
`else
  assign w_mkAddr = r_addr;
  assign w_mkCnt  = 4'd0;
  assign w_push   = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_id       <= '0;
      r_addr     <= '0;
      r_push     <= 1'b0;
      r_logWen   <= 1'b0;
      r_ptrLoad  <= 1'b0;
      r_stall    <= 1'b0;
      r_logAddr  <= '0;
      r_logData  <= '0;
      r_ptrValue <= '0;
      r_busyErr  <= 1'b0;
    end else begin
      if (bus.detect_active && (r_state != IDLE))
        r_busyErr <= 1'b1;
      case (r_state)
        IDLE: begin
          if (bus.detect_active) begin
            r_id    <= bus.active_block_id;
            r_addr  <= bus.active_block_cflog_addr;
            r_stall <= 1'b1;
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_logWen   <= 1'b1;
          r_logAddr  <= w_mkAddr;
          r_logData  <= {SPEC_TAG, w_mkCnt, r_id};
          r_ptrLoad  <= 1'b1;
          r_ptrValue <= w_mkAddr + 16'd1;
          r_push     <= w_push;
          r_state    <= WRITE;
        end
        WRITE: begin
          r_logWen   <= 1'b0;
          r_logAddr  <= '0;
          r_logData  <= '0;
          r_ptrLoad  <= 1'b0;
          r_ptrValue <= '0;
          r_stall    <= 1'b0;
          r_push     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  logic [7:0]    r_stackId   [DEPTH];
  logic [15:0]   r_stackAddr [DEPTH];
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_empty;
  logic          w_full;
  logic          w_pushReq;
  logic          w_popReq;
  logic [AW-1:0] w_topIdx;
  logic [AW-1:0] w_pushIdx;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pushReq = (r_state == WRITE) && r_push;
  assign w_popReq  = bus.stack_pop && !w_empty;
  assign w_topIdx  = AW'(r_count - CW'(1));
  assign w_pushIdx = AW'(r_count);

  // Simultaneous push and pop replaces the top entry, so it never overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_pushReq && w_popReq) begin
      r_count <= r_count;
    end else if (w_pushReq) begin
      if (w_full)
        r_ovf <= 1'b1;
      else
        r_count <= r_count + CW'(1);
    end else if (w_popReq) begin
      r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_pushReq) begin
      if (w_popReq) begin
        r_stackId[w_topIdx]   <= r_id;
        r_stackAddr[w_topIdx] <= r_logAddr;
      end else if (!w_full) begin
        r_stackId[w_pushIdx]   <= r_id;
        r_stackAddr[w_pushIdx] <= r_logAddr;
      end
    end
  end

  // Write-side strobes are masked while rst is high so an aborted WRITE never reaches the log.
  assign bus.log_wen        = r_logWen && !rst;
  assign bus.log_addr       = rst ? '0 : r_logAddr;
  assign bus.log_data       = rst ? '0 : r_logData;
  assign bus.log_ptr_load   = r_ptrLoad && !rst;
  assign bus.log_ptr_value  = rst ? '0 : r_ptrValue;
  assign bus.acfa_stall     = r_stall;
  assign bus.busy_err       = r_busyErr;
  assign bus.stack_count    = r_count;
  assign bus.stack_empty    = w_empty;
  assign bus.stack_ovf      = r_ovf;
  assign bus.stack_top_id   = w_empty ? '0 : r_stackId[w_topIdx];
  assign bus.stack_top_addr = w_empty ? '0 : r_stackAddr[w_topIdx];
endmodule
